// File: rtl/morse_recognize_char.sv
// Morse symbol recognizer: decodes a received dit/dah pattern into a character code,
// combinationally and registered. Define MORSE_PUNCT_EN to also recognize '/', '=' and '+'.
module morse_recognize_char #(
    parameter int unsigned CHAR_W        = 6,
    parameter int unsigned MAX_MORSE_LEN = 5,
    parameter int unsigned MORSE_LEN_W   = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [MORSE_LEN_W-1:0]   len,
    input  logic [MAX_MORSE_LEN-1:0] dits_dahs,
    output logic [CHAR_W-1:0]        char,
    output logic [CHAR_W-1:0]        char_q,
    output logic                     unknown_q
);

    localparam int unsigned TBL_W   = 5;
    localparam int unsigned COPY_W  = (MAX_MORSE_LEN < TBL_W) ? MAX_MORSE_LEN : TBL_W;

    localparam logic [CHAR_W-1:0] CHAR_CODE_SPACE   = CHAR_W'(36);
    localparam logic [CHAR_W-1:0] CHAR_CODE_UNKNOWN = CHAR_W'(63);

    logic [TBL_W-1:0]  pat;
    logic [CHAR_W-1:0] char_d;
    logic              unknown_d;

    // Keep only the elements actually received; later bits are don't-care.
    always_comb begin
        pat = '0;
        for (int unsigned i = 0; i < COPY_W; i++) begin
            if (i < 32'(len)) pat[i] = dits_dahs[i];
        end
    end

    // Table lookup: element 0 is the LSB of each literal, 1 = dah.
    always_comb begin
        char = CHAR_CODE_UNKNOWN;
        if (32'(len) <= MAX_MORSE_LEN) begin
            case (32'(len))
                0: char = CHAR_CODE_SPACE;
                1: char = pat[0] ? CHAR_W'(29) : CHAR_W'(14);
                2: begin
                    case (pat[1:0])
                        2'b10:   char = CHAR_W'(10); // A
                        2'b00:   char = CHAR_W'(18); // I
                        2'b11:   char = CHAR_W'(22); // M
                        default: char = CHAR_W'(23); // N
                    endcase
                end
                3: begin
                    case (pat[2:0])
                        3'b001:  char = CHAR_W'(13); // D
                        3'b011:  char = CHAR_W'(16); // G
                        3'b101:  char = CHAR_W'(20); // K
                        3'b111:  char = CHAR_W'(24); // O
                        3'b010:  char = CHAR_W'(27); // R
                        3'b000:  char = CHAR_W'(28); // S
                        3'b100:  char = CHAR_W'(30); // U
                        default: char = CHAR_W'(32); // W
                    endcase
                end
                4: begin
                    case (pat[3:0])
                        4'b0001: char = CHAR_W'(11); // B
                        4'b0101: char = CHAR_W'(12); // C
                        4'b0100: char = CHAR_W'(15); // F
                        4'b0000: char = CHAR_W'(17); // H
                        4'b1110: char = CHAR_W'(19); // J
                        4'b0010: char = CHAR_W'(21); // L
                        4'b0110: char = CHAR_W'(25); // P
                        4'b1011: char = CHAR_W'(26); // Q
                        4'b1000: char = CHAR_W'(31); // V
                        4'b1001: char = CHAR_W'(33); // X
                        4'b1101: char = CHAR_W'(34); // Y
                        4'b0011: char = CHAR_W'(35); // Z
                        default: char = CHAR_CODE_UNKNOWN;
                    endcase
                end
                5: begin
                    case (pat)
                        5'b11111: char = CHAR_W'(0);
                        5'b11110: char = CHAR_W'(1);
                        5'b11100: char = CHAR_W'(2);
                        5'b11000: char = CHAR_W'(3);
                        5'b10000: char = CHAR_W'(4);
                        5'b00000: char = CHAR_W'(5);
                        5'b00001: char = CHAR_W'(6);
                        5'b00011: char = CHAR_W'(7);
                        5'b00111: char = CHAR_W'(8);
                        5'b01111: char = CHAR_W'(9);
`ifdef MORSE_PUNCT_EN
                        5'b01001: char = CHAR_W'(37); // '/'
                        5'b10001: char = CHAR_W'(38); // '='
                        5'b01010: char = CHAR_W'(39); // '+'
`endif
                        default:  char = CHAR_CODE_UNKNOWN;
                    endcase
                end
                default: char = CHAR_CODE_UNKNOWN;
            endcase
        end
    end

    assign char_d    = char;
    assign unknown_d = (char == CHAR_CODE_UNKNOWN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            char_q    <= CHAR_CODE_SPACE;
            unknown_q <= 1'b0;
        end else begin
            char_q    <= char_d;
            unknown_q <= unknown_d;
        end
    end

endmodule

// File: tb/tb_morse_recognize_char.sv
// Directed bench for morse_recognize_char: combinational decode, registered outputs, async reset.
module tb_morse_recognize_char;

    logic       clk;
    logic       rst;
    logic [2:0] len;
    logic [4:0] dits_dahs;
    logic [5:0] char;
    logic [5:0] char_q;
    logic       unknown_q;

    int n_cmp = 0;
    int n_err = 0;

`ifdef MORSE_PUNCT_EN
    localparam logic [5:0] EXP_SLASH = 6'd37;
    localparam logic [5:0] EXP_EQ    = 6'd38;
`else
    localparam logic [5:0] EXP_SLASH = 6'd63;
    localparam logic [5:0] EXP_EQ    = 6'd63;
`endif

    morse_recognize_char dut (
        .clk       (clk),
        .rst       (rst),
        .len       (len),
        .dits_dahs (dits_dahs),
        .char      (char),
        .char_q    (char_q),
        .unknown_q (unknown_q)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive a pattern, check the same-cycle decode, then the registered copy after one edge.
    task automatic step(input string tag, input logic [2:0] l, input logic [4:0] b,
                        input logic [5:0] exp_char);
        @(negedge clk);
        len       = l;
        dits_dahs = b;
        #1;
        chk({tag, "_char"}, 32'(char), 32'(exp_char));
        @(posedge clk);
        #1;
        chk({tag, "_char_q"}, 32'(char_q), 32'(exp_char));
        chk({tag, "_unknown_q"}, 32'(unknown_q), 32'(exp_char == 6'd63));
    endtask

    initial begin
        rst       = 1'b1;
        len       = 3'd2;
        dits_dahs = 5'b00010;
        #1;
        chk("reset_char_q", 32'(char_q), 32'd36);
        chk("reset_unknown_q", 32'(unknown_q), 32'd0);
        chk("reset_char_comb", 32'(char), 32'd10);

        @(negedge clk);
        rst = 1'b0;

        step("A",       3'd2, 5'b00010, 6'd10);
        step("E",       3'd1, 5'b00000, 6'd14);
        step("E_upper", 3'd1, 5'b11110, 6'd14);
        step("T",       3'd1, 5'b00001, 6'd29);
        step("digit0",  3'd5, 5'b11111, 6'd0);
        step("digit5",  3'd5, 5'b00000, 6'd5);
        step("digit9",  3'd5, 5'b01111, 6'd9);
        step("space",   3'd0, 5'b10101, 6'd36);
        step("Q",       3'd4, 5'b01011, 6'd26);
        step("Z",       3'd4, 5'b00011, 6'd35);
        step("W_upper", 3'd3, 5'b11110, 6'd32);
        step("unk4",    3'd4, 5'b01100, 6'd63);
        step("len6",    3'd6, 5'b00010, 6'd63);
        step("len7",    3'd7, 5'b11111, 6'd63);
        step("slash",   3'd5, 5'b01001, EXP_SLASH);
        step("equals",  3'd5, 5'b10001, EXP_EQ);
        step("A_again", 3'd2, 5'b00010, 6'd10);

        // Async reset mid-stream while char_q holds 'A'.
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_char_q", 32'(char_q), 32'd36);
        chk("midrst_unknown_q", 32'(unknown_q), 32'd0);
        len       = 3'd1;
        dits_dahs = 5'b00001;
        #1;
        chk("midrst_char_comb", 32'(char), 32'd29);
        @(posedge clk);
        #1;
        chk("midrst_hold_char_q", 32'(char_q), 32'd36);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_char_q", 32'(char_q), 32'd29);
        chk("post_rst_unknown_q", 32'(unknown_q), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/morse_recognize_char.md
MORSE_RECOGNIZE_CHAR -- requirements
Module: morse_recognize_char

Interface
REQ-001 Parameter CHAR_W, default 6, width of the character code.
REQ-002 Parameter MAX_MORSE_LEN, default 5, maximum number of elements in a symbol.
REQ-003 Parameter MORSE_LEN_W, default 3, width of the length input.
REQ-004 clk  input  1  single clock; all registers SHALL be rising-edge clocked.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 len  input  MORSE_LEN_W  number of valid elements in dits_dahs (0..MAX_MORSE_LEN).
REQ-007 dits_dahs  input  MAX_MORSE_LEN  element i (i=0 first received) at bit i; 0=dit, 1=dah.
REQ-008 char  output  CHAR_W  combinational character code of the current inputs.
REQ-009 char_q  output  CHAR_W  char registered once per clk.
REQ-010 unknown_q  output  1  registered flag: previous-cycle pattern was not recognized.

Function
REQ-011 char SHALL be purely combinational from len and dits_dahs, with zero latency, so a word decoder can sample it on the same edge.
REQ-012 Bits dits_dahs[i] with i >= len SHALL be ignored.
REQ-013 Code map: digits '0'..'9' = 0..9; letters 'A'..'Z' = 10..35; space = 36 (CHAR_CODE_SPACE); unknown = 63 (CHAR_CODE_UNKNOWN).
REQ-014 Letters and digits SHALL follow the ITU-R M.1677-1 patterns (letters 1-4 elements, digits 5 elements).
REQ-015 len=0 SHALL yield 36 (space).
REQ-016 len > MAX_MORSE_LEN, or any pattern not in the enabled table, SHALL yield 63.
REQ-017 Each rising clk edge: char_q <= char; unknown_q <= (char == 63).
REQ-018 Registered outputs SHALL have exactly 1-cycle latency relative to the inputs; there is no enable and no handshake.
REQ-019 Codes 37..62 are reserved and SHALL never be output, except as allowed by REQ-023.

Reset
REQ-020 While rst=1, char_q SHALL be 36 and unknown_q SHALL be 0, immediately and independently of clk.
REQ-021 char SHALL be unaffected by rst.
REQ-022 After rst deasserts, the first rising edge SHALL load char_q and unknown_q normally.

Configuration
REQ-023 Macro MORSE_PUNCT_EN defined: the following SHALL also be recognized: '/' (-..-.) = 37, '=' (-...-) = 38, '+' (.-.-.) = 39.
REQ-024 Macro MORSE_PUNCT_EN undefined: those three patterns SHALL yield 63, and codes 37..39 SHALL never be output.

Verification
REQ-025 len=2, dits_dahs=5'b00010 ('A') -> char=10 in the same cycle; char_q=10 and unknown_q=0 after the next edge.
REQ-026 len=1 with dits_dahs=5'b00000 -> 14 ('E'); len=1 with 5'b11110 -> 14 (upper bits ignored); len=1 with 5'b00001 -> 29 ('T').
REQ-027 len=5, dits_dahs=5'b11111 -> 0 ('0'); len=5, 5'b00000 -> 5 ('5'); len=0 with any bits -> 36.
REQ-028 len=4, dits_dahs=5'b01100 ("..--") -> 63, with unknown_q=1 after the edge; len=6 -> 63.
REQ-029 len=5, dits_dahs=5'b01001 ("-..-.") -> 37 with MORSE_PUNCT_EN defined, 63 without it.
REQ-030 Assert rst mid-stream while char_q=10 -> char_q=36 and unknown_q=0 with no clk edge; char still tracks the inputs.
